// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: lpGBT frame-alignment sequencer for the GTX RX side.
// It hunts for a stable 2'b01 frame header and issues one-cycle bitslip
// pulses, letting the gearbox settle after each one. Once the header is
// stable it holds lock and gates data, and it re-hunts when lock is lost.
// After too many slips it backs off for a while, then tries again.
module frame_align_ctrl #(
  parameter int unsigned LOCK_CNT   = 20,
  parameter int unsigned LOSS_CNT   = 4,
  parameter int unsigned SLIP_WAIT  = 32,
  parameter int unsigned MAX_SLIPS  = 66,
  parameter int unsigned RETRY_WAIT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hdr_valid,
  input  logic [1:0] header,
  output logic       bitslip,
  output logic       locked,
  output logic       d_enb,
  output logic       align_fail,
  output logic [2:0] state,
  output logic [7:0] slip_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_SLIP   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  good_cnt;
  logic [7:0]  bad_cnt;
  logic [15:0] wait_cnt;
  logic [7:0]  slip_q;
  logic [7:0]  relock_q;

  logic hdr_good, hdr_bad;
  logic good_hit, bad_hit, slips_max, slip_wait_done, retry_done;
  logic bitslip_d, locked_d, d_enb_d, align_fail_d;

  // Header classification and counter threshold flags.
  always_comb begin
    hdr_good       = hdr_valid && (header == 2'b01);
    hdr_bad        = hdr_valid && (header != 2'b01);
    // Thresholds compare against N-1 so the header sampled on the
    // reaching edge is the one that completes the count.
    good_hit       = (good_cnt == 8'(LOCK_CNT - 1));
    bad_hit        = (bad_cnt  == 8'(LOSS_CNT - 1));
    slips_max      = (slip_q   == 8'(MAX_SLIPS));
    slip_wait_done = (wait_cnt == 16'(SLIP_WAIT - 1));
    retry_done     = (wait_cnt == 16'(RETRY_WAIT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a low enable overrides every transition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_HUNT;
        S_HUNT: begin
          if (hdr_good && good_hit) state_d = S_LOCKED;
          else if (hdr_bad)         state_d = slips_max ? S_FAIL : S_SLIP;
        end
        S_SLIP:   state_d = S_WAIT;
        S_WAIT:   if (slip_wait_done) state_d = S_HUNT;
        S_LOCKED: if (hdr_bad && bad_hit) state_d = S_HUNT;
        S_FAIL:   if (retry_done) state_d = S_HUNT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode, feeding the registered outputs below.
  always_comb begin
    bitslip_d    = (state_d == S_SLIP);
    locked_d     = (state_d == S_LOCKED);
    align_fail_d = (state_d == S_FAIL);
    d_enb_d      = enable && (state_q == S_LOCKED) && hdr_good;
  end

  // Registered outputs; the async reset drops a pulse in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      d_enb      <= 1'b0;
      align_fail <= 1'b0;
    end else begin
      bitslip    <= bitslip_d;
      locked     <= locked_d;
      d_enb      <= d_enb_d;
      align_fail <= align_fail_d;
    end
  end

  // Good/bad/wait/slip/relock counters.
  // wait_cnt is shared by the settle and retry timers; it is zero whenever
  // the FSM is outside WAIT and FAIL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      wait_cnt <= '0;
      slip_q   <= '0;
      relock_q <= '0;
    end else if (!enable) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      wait_cnt <= '0;
      slip_q   <= '0;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (hdr_good)     good_cnt <= good_hit ? '0 : good_cnt + 8'd1;
          else if (hdr_bad) good_cnt <= '0;
        end
        S_SLIP: slip_q <= slip_q + 8'd1;
        S_WAIT: begin
          wait_cnt <= slip_wait_done ? '0 : wait_cnt + 16'd1;
          if (slip_wait_done) good_cnt <= '0;
        end
        S_LOCKED: begin
          if (hdr_good) begin
            bad_cnt <= '0;
          end else if (hdr_bad) begin
            if (bad_hit) begin
              bad_cnt <= '0;
              slip_q  <= '0;
              if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
            end else begin
              bad_cnt <= bad_cnt + 8'd1;
            end
          end
        end
        S_FAIL: begin
          if (retry_done) begin
            wait_cnt <= '0;
            slip_q   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign slip_cnt   = slip_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Testbench for frame_align_ctrl. It uses scenario tasks and a randomized
// phase, and checks against a deadline-based reference model.
module tb_frame_align_ctrl;

  localparam int LOCK_CNT = 20, LOSS_CNT = 4, SLIP_WAIT = 32, MAX_SLIPS = 66, RETRY_WAIT = 1024;
  localparam int M_IDLE = 0, M_HUNT = 1, M_SLIP = 2, M_WAIT = 3, M_LOCKED = 4, M_FAIL = 5;

  logic clk, rst_n, enable, hdr_valid;
  logic [1:0] header;
  logic bitslip, locked, d_enb, align_fail;
  logic [2:0] state;
  logic [7:0] slip_cnt, relock_cnt;

  int errors = 0;
  int checks = 0;

  frame_align_ctrl #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .SLIP_WAIT(SLIP_WAIT),
                     .MAX_SLIPS(MAX_SLIPS), .RETRY_WAIT(RETRY_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hdr_valid(hdr_valid), .header(header),
    .bitslip(bitslip), .locked(locked), .d_enb(d_enb), .align_fail(align_fail),
    .state(state), .slip_cnt(slip_cnt), .relock_cnt(relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] dut_vec;
  assign dut_vec = {bitslip, locked, d_enb, align_fail, state, slip_cnt, relock_cnt};

  // Reference model: mode plus absolute deadlines (edge numbers) for timed phases.
  int m_mode, m_good, m_bad, m_slips, m_relock, m_until, cyc;
  logic m_denb;

  function automatic logic [22:0] model_vec();
    return {m_mode == M_SLIP, m_mode == M_LOCKED, m_denb, m_mode == M_FAIL,
            3'(m_mode), 8'(m_slips), 8'(m_relock)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_good = 0; m_bad = 0; m_slips = 0; m_relock = 0; m_until = 0; m_denb = 1'b0;
  endtask

  task automatic model_step();
    int prev;
    logic g, b;
    cyc++;
    if (!rst_n) begin model_reset(); return; end
    prev = m_mode;
    g = hdr_valid && (header == 2'b01);
    b = hdr_valid && (header != 2'b01);
    if (!enable) begin
      m_mode = M_IDLE; m_good = 0; m_bad = 0; m_slips = 0; m_denb = 1'b0;
      return;
    end
    m_denb = (prev == M_LOCKED) && g;
    case (prev)
      M_IDLE: m_mode = M_HUNT;
      M_HUNT: begin
        if (g) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_mode = M_LOCKED; m_good = 0; end
        end else if (b) begin
          m_good = 0;
          if (m_slips == MAX_SLIPS) begin m_mode = M_FAIL; m_until = cyc + RETRY_WAIT; end
          else m_mode = M_SLIP;
        end
      end
      M_SLIP: begin m_slips++; m_mode = M_WAIT; m_until = cyc + SLIP_WAIT; end
      M_WAIT: if (cyc == m_until) begin m_mode = M_HUNT; m_good = 0; end
      M_LOCKED: begin
        if (g) m_bad = 0;
        else if (b) begin
          m_bad++;
          if (m_bad == LOSS_CNT) begin
            m_bad = 0; m_mode = M_HUNT; m_slips = 0;
            if (m_relock < 255) m_relock++;
          end
        end
      end
      M_FAIL: if (cyc == m_until) begin m_slips = 0; m_mode = M_HUNT; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Apply inputs, take one clock edge, update the model, sample 1 time unit later.
  task automatic step(input logic en, input logic v, input logic [1:0] h);
    enable = en; hdr_valid = v; header = h;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; hdr_valid = 1'b0; header = 2'b00;
    model_reset();
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b1, 2'b01);
    checks++;
    if (dut_vec !== 23'd0) begin errors++; $display("FAIL reset_state got %h want %h", dut_vec, 23'd0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int nslip = 0;
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL lock_enter_hunt got %0d want 1", state); end
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b1, 2'b01);
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL lock_model i=%0d got %h want %h", i, dut_vec, model_vec()); end
      if (bitslip) nslip++;
      if (i == 18) begin checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end end
      if (i == 19) begin checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_20th got %b want 1", locked); end end
      if (i == 20) begin checks++; if (d_enb !== 1'b1) begin errors++; $display("FAIL lock_denb got %b want 1", d_enb); end end
    end
    checks++;
    if (nslip != 0 || slip_cnt !== 8'd0) begin errors++; $display("FAIL lock_noslip got slips=%0d cnt=%0d want 0/0", nslip, slip_cnt); end
  endtask

  task automatic test_slip();
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    checks++;
    if (state !== 3'd2 || bitslip !== 1'b1) begin errors++; $display("FAIL slip_pulse got st=%0d bs=%b want 2/1", state, bitslip); end
    step(1'b1, 1'b1, 2'b11);
    checks++;
    if (state !== 3'd3 || bitslip !== 1'b0 || slip_cnt !== 8'd1) begin
      errors++; $display("FAIL slip_one_cycle got st=%0d bs=%b cnt=%0d want 3/0/1", state, bitslip, slip_cnt);
    end
    for (int i = 0; i < SLIP_WAIT - 1; i++) begin
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)));
      checks++;
      if (state !== 3'd3 || bitslip !== 1'b0 || dut_vec !== model_vec()) begin
        errors++; $display("FAIL slip_wait i=%0d got %h want %h", i, dut_vec, model_vec());
      end
    end
    step(1'b1, 1'b1, 2'b10);
    checks++;
    if (state !== 3'd1 || slip_cnt !== 8'd1) begin errors++; $display("FAIL slip_rehunt got st=%0d cnt=%0d want 1/1", state, slip_cnt); end
    for (int i = 0; i < LOCK_CNT; i++) step(1'b1, 1'b1, 2'b01);
    checks++;
    if (locked !== 1'b1 || dut_vec !== model_vec()) begin errors++; $display("FAIL slip_relock got %h want %h", dut_vec, model_vec()); end
  endtask

  task automatic test_fail();
    int pulses = 0, last = 0, fcount = 0;
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < MAX_SLIPS * (SLIP_WAIT + 2) + 200; i++) begin
      step(1'b1, 1'b1, 2'b00);
      checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL fail_model i=%0d got %h want %h", i, dut_vec, model_vec()); end
      if (bitslip) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (cyc - last != SLIP_WAIT + 2) begin errors++; $display("FAIL fail_spacing got %0d want %0d", cyc - last, SLIP_WAIT + 2); end
        end
        last = cyc;
      end
      if (align_fail) break;
    end
    checks++;
    if (pulses != MAX_SLIPS || align_fail !== 1'b1) begin
      errors++; $display("FAIL fail_pulses got %0d fail=%b want %0d/1", pulses, align_fail, MAX_SLIPS);
    end
    fcount = align_fail ? 1 : 0;
    for (int i = 0; i < RETRY_WAIT + 100 && align_fail; i++) begin
      step(1'b1, 1'b1, 2'b00);
      if (align_fail) fcount++;
    end
    checks++;
    if (fcount != RETRY_WAIT || state !== 3'd1 || slip_cnt !== 8'd0 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL fail_retry got len=%0d st=%0d cnt=%0d want %0d/1/0", fcount, state, slip_cnt, RETRY_WAIT);
    end
  endtask

  task automatic test_loss();
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < LOCK_CNT; i++) step(1'b1, 1'b1, 2'b01);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL loss_lock got %b want 1", locked); end
    for (int i = 0; i < LOSS_CNT - 1; i++) step(1'b1, 1'b1, 2'b11);
    checks++;
    if (locked !== 1'b1 || state !== 3'd4 || d_enb !== 1'b0) begin
      errors++; $display("FAIL loss_hold got lk=%b st=%0d de=%b want 1/4/0", locked, state, d_enb);
    end
    step(1'b1, 1'b1, 2'b01);
    checks++;
    if (locked !== 1'b1 || d_enb !== 1'b1) begin errors++; $display("FAIL loss_good got lk=%b de=%b want 1/1", locked, d_enb); end
    step(1'b1, 1'b0, 2'b01);
    checks++;
    if (d_enb !== 1'b0) begin errors++; $display("FAIL loss_denb_pulse got %b want 0", d_enb); end
    for (int i = 0; i < LOSS_CNT; i++) step(1'b1, 1'b1, 2'b00);
    checks++;
    if (locked !== 1'b0 || state !== 3'd1 || relock_cnt !== 8'd1 || slip_cnt !== 8'd0 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL loss_drop got %h want lk=0 st=1 relock=1 (model %h)", dut_vec, model_vec());
    end
  endtask

  task automatic test_enable();
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b01);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL en_in_wait got %0d want 3", state); end
    step(1'b0, 1'b1, 2'b01);
    checks++;
    if (dut_vec !== 23'd1) begin errors++; $display("FAIL en_off_wait got %h want %h", dut_vec, 23'd1); end
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < LOCK_CNT + 1; i++) step(1'b1, 1'b1, 2'b01);
    checks++;
    if (locked !== 1'b1 || d_enb !== 1'b1) begin errors++; $display("FAIL en_relock got lk=%b de=%b want 1/1", locked, d_enb); end
    step(1'b0, 1'b1, 2'b01);
    checks++;
    if (dut_vec !== 23'd1 || dut_vec !== model_vec()) begin errors++; $display("FAIL en_off_locked got %h want %h", dut_vec, 23'd1); end
  endtask

  task automatic test_async_reset_and_saturate();
    int want;
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b10);
    checks++;
    if (bitslip !== 1'b1 || relock_cnt !== 8'd1) begin errors++; $display("FAIL ar_in_slip got bs=%b rl=%0d want 1/1", bitslip, relock_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 23'd0) begin errors++; $display("FAIL ar_async_clear got %h want 0", dut_vec); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b00);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < LOCK_CNT; i++) step(1'b1, 1'b1, 2'b01);
      for (int i = 0; i < LOSS_CNT; i++) step(1'b1, 1'b1, 2'($urandom_range(0, 1) ? 2'b11 : 2'b00));
      want = (k + 1 > 255) ? 255 : k + 1;
      checks++;
      if (relock_cnt !== 8'(want) || state !== 3'd1 || dut_vec !== model_vec()) begin
        errors++; $display("FAIL sat_event k=%0d got rl=%0d st=%0d want %0d/1", k, relock_cnt, state, want);
      end
    end
  endtask

  task automatic test_random();
    int badp;
    logic en, v;
    logic [1:0] h;
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: badp = 0;
        1: badp = 2;
        2: badp = 10;
        default: badp = 60;
      endcase
      for (int i = 0; i < 400; i++) begin
        en = ($urandom_range(0, 199) != 0);
        v  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < badp) begin
          case ($urandom_range(0, 2))
            0: h = 2'b00;
            1: h = 2'b10;
            default: h = 2'b11;
          endcase
        end else h = 2'b01;
        step(en, v, h);
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL random seg=%0d i=%0d got %h want %h", seg, i, dut_vec, model_vec());
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    test_reset();
    test_lock();
    test_slip();
    test_fail();
    test_loss();
    test_enable();
    test_async_reset_and_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
